// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the proc memory port and its RAM.
//   DW          - default data/bus width, matching the proc datapath
//   AW          - default address width of the memory port
//   mem_state_t - memory port FSM state (clear sweep, normal traffic)
package proc_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } mem_state_t;

endpackage

// File: rtl/sync_ram_sp.sv
// sync_ram_sp: single-port synchronous RAM, 2^AW words of DW bits.
//   Clock - rising-edge clock
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   rdata - registered read data; on a write it returns wdata (write-first)
// The array has no reset; the memory port clears it with a sweep.
module sync_ram_sp #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          Clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem [Depth];

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/proc_mem_port.sv
// proc_mem_port: single-port instruction/data memory controller for proc.
//   Clock      - rising-edge clock
//   Resetn     - asynchronous reset, active high (1 resets)
//   R7         - fetch address (PC)
//   Daddress   - data address for loads and stores
//   memControl - 1 selects Daddress for reads, 0 selects R7
//   w          - write strobe (always addresses Daddress)
//   q          - store data
//   DIN        - read data, one cycle after the address; write-through on stores
//   Ready      - high once the post-reset zero-fill sweep is complete
//   AddrErr    - sticky; an access used an address with bits set at or above AW
// After each reset the RAM is swept to zero, one word per cycle, before any
// processor traffic is accepted.
import proc_pkg::*;

module proc_mem_port #(
    parameter int unsigned AW = proc_pkg::AW,
    parameter int unsigned DW = proc_pkg::DW
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic [DW-1:0] R7,
    input  logic [DW-1:0] Daddress,
    input  logic          memControl,
    input  logic          w,
    input  logic [DW-1:0] q,
    output logic [DW-1:0] DIN,
    output logic          Ready,
    output logic          AddrErr
);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          ready_q, ready_d;
    logic          addr_err_q, addr_err_d;
    logic          rd_valid_q, rd_valid_d;

    logic [DW-1:0] sel_addr;
    logic          out_of_range;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ready_d    = ready_q;
        addr_err_d = addr_err_q;
        rd_valid_d = rd_valid_q;

        // Stores always go to Daddress, whatever memControl says.
        sel_addr     = (w || memControl) ? Daddress : R7;
        out_of_range = (sel_addr >> AW) != '0;

        ram_we    = 1'b0;
        ram_addr  = sel_addr[AW-1:0];
        ram_wdata = q;

        unique case (state_q)
            StClear: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + AW'(1);
                rd_valid_d = 1'b0;
                if (&clr_addr_q) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                ram_we     = w;
                rd_valid_d = 1'b1;
                if (out_of_range) begin
                    addr_err_d = 1'b1;
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    sync_ram_sp #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .Clock(Clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // The unreset RAM output is masked until the first RUN access has been
    // captured, so DIN reads 0 from reset through the end of the sweep.
    assign DIN     = rd_valid_q ? ram_rdata : '0;
    assign Ready   = ready_q;
    assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_proc_mem_port.sv
// tb_proc_mem_port: self-checking bench for proc_mem_port with AW=4.
// A reference memory array predicts read data; expected DIN values are
// queued when an access is issued and popped after the clock edge.
module tb_proc_mem_port;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic [DW-1:0] R7;
    logic [DW-1:0] Daddress;
    logic          memControl;
    logic          w;
    logic [DW-1:0] q;
    logic [DW-1:0] DIN;
    logic          Ready;
    logic          AddrErr;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] sb [$];

    always #5 Clock = ~Clock;

    proc_mem_port #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .R7        (R7),
        .Daddress  (Daddress),
        .memControl(memControl),
        .w         (w),
        .q         (q),
        .DIN       (DIN),
        .Ready     (Ready),
        .AddrErr   (AddrErr)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        w          = 1'b0;
        memControl = 1'b0;
        R7         = '0;
        Daddress   = '0;
        q          = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
    endtask

    // Drive one RUN-state access and queue the DIN value it should produce.
    task automatic issue(input logic wr, input logic mc, input logic [DW-1:0] pc,
                         input logic [DW-1:0] da, input logic [DW-1:0] wd);
        logic [3:0] idx;
        w          = wr;
        memControl = mc;
        R7         = pc;
        Daddress   = da;
        q          = wd;
        if (wr) begin
            idx = da[3:0];
            model_mem[idx] = wd;
            sb.push_back(wd);
        end else begin
            idx = mc ? da[3:0] : pc[3:0];
            sb.push_back(model_mem[idx]);
        end
    endtask

    task automatic test_reset();
        logic exp_rdy;
        logic [DW-1:0] exp;
        idle();
        Resetn = 1'b1;
        step();
        step();
        n_checks++;
        if (DIN !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_din: got %h expected 0000", DIN);
        end
        n_checks++;
        if (Ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 0", Ready);
        end
        n_checks++;
        if (AddrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_addrerr: got %b expected 0", AddrErr);
        end
        Resetn = 1'b0;
        clear_model();
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_rdy = (i == 16);
            n_checks++;
            if (Ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL sweep_ready edge %0d: got %b expected %b", i, Ready, exp_rdy);
            end
        end
        for (int a = 0; a < 16; a++) begin
            issue(1'b0, 1'b0, 16'(a), 16'h0005, 16'h0000);
            step();
            exp = sb.pop_front();
            n_checks++;
            if (DIN !== exp) begin
                n_errors++;
                $display("FAIL zero_read addr %0d: got %h expected %h", a, DIN, exp);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp;
        issue(1'b1, 1'b0, 16'h0000, 16'h0005, 16'hBEEF);
        step();
        exp = sb.pop_front();
        n_checks++;
        if (DIN !== exp) begin
            n_errors++;
            $display("FAIL write_through: got %h expected %h", DIN, exp);
        end
        issue(1'b0, 1'b1, 16'h0000, 16'h0005, 16'h0000);
        step();
        exp = sb.pop_front();
        n_checks++;
        if (DIN !== exp) begin
            n_errors++;
            $display("FAIL read_after_write: got %h expected %h", DIN, exp);
        end
        n_checks++;
        if (AddrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL addrerr_inrange: got %b expected 0", AddrErr);
        end
        idle();
    endtask

    task automatic test_fetch();
        logic [DW-1:0] exp;
        issue(1'b1, 1'b0, 16'h0000, 16'h0003, 16'h1234);
        step();
        void'(sb.pop_front());
        issue(1'b1, 1'b1, 16'h0000, 16'h0005, 16'h5678);
        step();
        void'(sb.pop_front());
        // Reads: fetch via R7, then data via Daddress, then back-to-back fetches.
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       issue(1'b0, 1'b0, 16'h0003, 16'h0005, 16'h0000);
                1:       issue(1'b0, 1'b1, 16'h0003, 16'h0005, 16'h0000);
                2:       issue(1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0000);
                default: issue(1'b0, 1'b0, 16'h0009, 16'h0003, 16'h0000);
            endcase
            step();
            exp = sb.pop_front();
            n_checks++;
            if (DIN !== exp) begin
                n_errors++;
                $display("FAIL addr_select step %0d: got %h expected %h", k, DIN, exp);
            end
        end
        idle();
    endtask

    task automatic test_addr_err();
        logic [DW-1:0] exp;
        issue(1'b1, 1'b0, 16'h0000, 16'h0013, 16'h00AA);
        step();
        exp = sb.pop_front();
        n_checks++;
        if (DIN !== exp) begin
            n_errors++;
            $display("FAIL oob_write_through: got %h expected %h", DIN, exp);
        end
        n_checks++;
        if (AddrErr !== 1'b1) begin
            n_errors++;
            $display("FAIL addrerr_set: got %b expected 1", AddrErr);
        end
        issue(1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000);
        step();
        exp = sb.pop_front();
        n_checks++;
        if (DIN !== exp) begin
            n_errors++;
            $display("FAIL oob_alias_read: got %h expected %h", DIN, exp);
        end
        idle();
        step();
        step();
        n_checks++;
        if (AddrErr !== 1'b1) begin
            n_errors++;
            $display("FAIL addrerr_sticky: got %b expected 1", AddrErr);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic exp_rdy;
        logic [DW-1:0] exp;
        issue(1'b1, 1'b0, 16'h0000, 16'h0009, 16'h4242);
        step();
        void'(sb.pop_front());
        // Reset asserted alongside a store: the store must be dropped.
        w        = 1'b1;
        Daddress = 16'h000A;
        q        = 16'h7777;
        Resetn   = 1'b1;
        step();
        n_checks++;
        if (AddrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL addrerr_reset: got %b expected 0", AddrErr);
        end
        idle();
        Resetn = 1'b0;
        for (int i = 0; i < 7; i++) step();
        Resetn = 1'b1;
        step();
        Resetn = 1'b0;
        clear_model();
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_rdy = (i == 16);
            n_checks++;
            if (Ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL resweep_ready edge %0d: got %b expected %b", i, Ready, exp_rdy);
            end
        end
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, 1'b1, 16'h0000, (k == 0) ? 16'h0009 : 16'h000A, 16'h0000);
            step();
            exp = sb.pop_front();
            n_checks++;
            if (DIN !== exp) begin
                n_errors++;
                $display("FAIL data_lost_after_reset %0d: got %h expected %h", k, DIN, exp);
            end
        end
        idle();
    endtask

    task automatic test_write_during_clear();
        logic [DW-1:0] exp;
        Resetn = 1'b1;
        step();
        Resetn   = 1'b0;
        w        = 1'b1;
        Daddress = 16'h0002;
        q        = 16'hFFFF;
        clear_model();
        for (int i = 1; i <= 16; i++) begin
            step();
            n_checks++;
            if (DIN !== 16'h0000) begin
                n_errors++;
                $display("FAIL din_during_clear edge %0d: got %h expected 0000", i, DIN);
            end
        end
        n_checks++;
        if (Ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_clear: got %b expected 1", Ready);
        end
        for (int a = 1; a <= 3; a++) begin
            issue(1'b0, 1'b1, 16'h0000, 16'(a), 16'h0000);
            step();
            exp = sb.pop_front();
            n_checks++;
            if (DIN !== exp) begin
                n_errors++;
                $display("FAIL clear_write_ignored addr %0d: got %h expected %h", a, DIN, exp);
            end
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        Resetn = 1'b1;
        test_reset();
        test_write_read();
        test_fetch();
        test_addr_err();
        test_reset_mid_clear();
        test_write_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
